// File: rtl/lisa_pkg.sv
// LISA shared definitions: datapath widths and the
// data-memory controller state encoding.
package lisa_pkg;

    localparam int LISA_ADDR_W = 16;
    localparam int LISA_DATA_W = 32;

    localparam logic [1:0] DM_IDLE = 2'd0;
    localparam logic [1:0] DM_BUSY = 2'd1;
    localparam logic [1:0] DM_DONE = 2'd2;

endpackage

// File: rtl/lisa_sram_1p.sv
// Single-port synchronous data array with a registered read port.
// Contents are never reset.
module lisa_sram_1p
    import lisa_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   en,
    input  logic                   we,
    input  logic [AW-1:0]          addr,
    input  logic [LISA_DATA_W-1:0] wdata,
    output logic [LISA_DATA_W-1:0] rdata
);

    logic [LISA_DATA_W-1:0] mem_q [DEPTH];
    logic [LISA_DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lisa_dmem_ctrl.sv
// LISA data-memory stage: request FSM, wait-state counter and
// address fault decode wrapped around the single-port array.
module lisa_dmem_ctrl
    import lisa_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    input  logic                   req_we,
    input  logic [LISA_ADDR_W-1:0] req_addr,
    input  logic [LISA_DATA_W-1:0] req_wdata,
    output logic                   req_ready,
    output logic                   busy,
    output logic                   rsp_valid,
    output logic [LISA_DATA_W-1:0] rsp_rdata,
    output logic                   rsp_err
);

    localparam int AW = $clog2(DEPTH);

    logic [1:0]             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   we_q, we_d;
    logic [LISA_ADDR_W-1:0] addr_q, addr_d;
    logic [LISA_DATA_W-1:0] wdata_q, wdata_d;
    logic                   rd_ok_q, rd_ok_d;
    logic                   err_q, err_d;

    logic                   commit;
    logic                   fault;
    logic                   c_we;
    logic [LISA_ADDR_W-1:0] c_addr;
    logic [LISA_DATA_W-1:0] c_wdata;
    logic                   sram_en;
    logic [LISA_DATA_W-1:0] sram_rdata;

    // With zero wait states the commit edge is the acceptance edge,
    // so the array is driven straight from the request inputs.
    always_comb begin
        c_we    = we_q;
        c_addr  = addr_q;
        c_wdata = wdata_q;
        commit  = 1'b0;
        if (state_q == DM_IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            commit  = req_valid && (WAIT_CYCLES == 0);
        end else if (state_q == DM_BUSY) begin
            commit  = (cnt_q == 4'd1);
        end
    end

    assign fault = (c_addr[1:0] != 2'b00)
                || (32'(c_addr[LISA_ADDR_W-1:2]) >= 32'(DEPTH));

    assign sram_en = commit && !fault && !rst;

    lisa_sram_1p #(
        .DEPTH (DEPTH)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (c_we),
        .addr  (c_addr[AW+1:2]),
        .wdata (c_wdata),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DM_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_ok_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_ok_q <= rd_ok_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_ok_d = rd_ok_q;
        err_d   = err_q;
        unique case (state_q)
            DM_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? DM_DONE : DM_BUSY;
                end
            end
            DM_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DM_DONE;
                end
            end
            DM_DONE: state_d = DM_IDLE;
            default: state_d = DM_IDLE;
        endcase
        if (commit) begin
            err_d   = fault;
            rd_ok_d = !fault && !c_we;
        end
    end

    always_comb begin
        req_ready = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            DM_IDLE: req_ready = 1'b1;
            DM_BUSY: busy = 1'b1;
            DM_DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: req_ready = 1'b0;
        endcase
    end

    // Stores and faults read back as zero; the value holds until the next DONE.
    assign rsp_rdata = rd_ok_q ? sram_rdata : '0;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_lisa_dmem_ctrl.sv
// Directed bench for lisa_dmem_ctrl: a 2-wait-state instance for the
// main sequence and a zero-wait instance for the latency corner.
module tb_lisa_dmem_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready, busy, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_we;
    logic [15:0] z_req_addr;
    logic [31:0] z_req_wdata;
    logic        z_req_ready, z_busy, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lisa_dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    lisa_dmem_ctrl #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (z_req_valid),
        .req_we    (z_req_we),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .req_ready (z_req_ready),
        .busy      (z_busy),
        .rsp_valid (z_rsp_valid),
        .rsp_rdata (z_rsp_rdata),
        .rsp_err   (z_rsp_err)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [15:0] a,
                        input logic [31:0] d, input logic inj,
                        output logic [31:0] rd, output logic er,
                        output int lat);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 99;
        rd  = 32'hFFFF_FFFF;
        er  = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("busy_inflight", 32'(busy), 32'd1);
                chk("ready_inflight", 32'(req_ready), 32'd0);
            end
            if (inj && i == 1) begin
                req_valid = 1'b1;
                req_we    = 1'b1;
                req_addr  = 16'h0020;
                req_wdata = 32'h1234_5678;
            end else begin
                req_valid = 1'b0;
            end
            if (rsp_valid) begin
                lat = i;
                rd  = rsp_rdata;
                er  = rsp_err;
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic ztx(input logic we, input logic [15:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
        @(negedge clk);
        z_req_valid = 1'b1;
        z_req_we    = we;
        z_req_addr  = a;
        z_req_wdata = d;
        @(posedge clk);
        #1 z_req_valid = 1'b0;
        @(negedge clk);
        chk("z_rsp_n1", 32'(z_rsp_valid), 32'd1);
        chk("z_busy_n1", 32'(z_busy), 32'd1);
        chk("z_ready_n1", 32'(z_req_ready), 32'd0);
        chk("z_rdata", z_rsp_rdata, exp_rd);
        chk("z_err", 32'(z_rsp_err), 32'd0);
        @(negedge clk);
        chk("z_ready_n2", 32'(z_req_ready), 32'd1);
        chk("z_busy_n2", 32'(z_busy), 32'd0);
        chk("z_rsp_n2", 32'(z_rsp_valid), 32'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          idx, nrsp, last, seen;
        logic [31:0] ex;

        rst         = 1'b1;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        z_req_valid = 1'b0;
        z_req_we    = 1'b0;
        z_req_addr  = '0;
        z_req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        chk("z_rst_ready", 32'(z_req_ready), 32'd1);
        rst = 1'b0;

        xact(1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b0, rd, er, lat);
        chk("st10_lat", 32'(lat), 32'(W + 1));
        chk("st10_err", 32'(er), 32'd0);
        chk("st10_rd", rd, 32'd0);

        xact(1'b0, 16'h0010, 32'h0, 1'b0, rd, er, lat);
        chk("ld10_lat", 32'(lat), 32'(W + 1));
        chk("ld10_rd", rd, 32'hDEAD_BEEF);
        chk("ld10_err", 32'(er), 32'd0);

        xact(1'b1, 16'h0012, 32'h5555_5555, 1'b0, rd, er, lat);
        chk("mis_err", 32'(er), 32'd1);
        chk("mis_rd", rd, 32'd0);

        xact(1'b0, 16'h0010, 32'h0, 1'b0, rd, er, lat);
        chk("ld10b_rd", rd, 32'hDEAD_BEEF);
        chk("ld10b_err", 32'(er), 32'd0);

        xact(1'b0, 16'h1000, 32'h0, 1'b0, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rd", rd, 32'd0);

        xact(1'b1, 16'h0020, 32'h1111_2222, 1'b0, rd, er, lat);
        xact(1'b1, 16'h0030, 32'h0000_0000, 1'b0, rd, er, lat);

        xact(1'b0, 16'h0010, 32'h0, 1'b1, rd, er, lat);
        chk("inj_lat", 32'(lat), 32'(W + 1));
        chk("inj_rd", rd, 32'hDEAD_BEEF);
        xact(1'b0, 16'h0020, 32'h0, 1'b0, rd, er, lat);
        chk("ld20_rd", rd, 32'h1111_2222);
        chk("ld20_lat", 32'(lat), 32'(W + 1));

        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0030;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_reset_vals("midrst");
        rst  = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("midrst_norsp", 32'(seen), 32'd0);

        xact(1'b0, 16'h0030, 32'h0, 1'b0, rd, er, lat);
        chk("ld30_rd", rd, 32'h0000_0000);
        chk("ld30_err", 32'(er), 32'd0);

        idx  = 0;
        nrsp = 0;
        last = 0;
        for (int cyc = 0; cyc < 200 && nrsp < 16; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ex = (nrsp % 2 == 0) ? 32'd0
                   : 32'hA500_0000 + 32'(nrsp / 2) * 32'h0101_0101;
                chk("b2b_rd", rsp_rdata, ex);
                chk("b2b_err", 32'(rsp_err), 32'd0);
                if (nrsp > 0) chk("b2b_gap", 32'(cyc - last), 32'(W + 2));
                last = cyc;
                nrsp++;
            end
            if (req_ready) begin
                if (idx < 16) begin
                    req_valid = 1'b1;
                    req_we    = (idx % 2 == 0);
                    req_addr  = 16'h0100 + 16'(4 * (idx / 2));
                    req_wdata = 32'hA500_0000 + 32'(idx / 2) * 32'h0101_0101;
                    idx++;
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_count", 32'(nrsp), 32'd16);

        ztx(1'b1, 16'h0008, 32'h0BAD_CAFE, 32'd0);
        ztx(1'b0, 16'h0008, 32'h0, 32'h0BAD_CAFE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
